// File: rtl/pipelined_adder.sv
// Pipelined add/subtract unit.
// The operands are cut into CHUNK-bit slices. Each pipeline stage adds one
// slice, and the carry is registered between stages. Upper operand slices
// travel down the pipe with the operation until their stage uses them. Lower
// result slices travel with it too, so every slice of one result comes out
// together.
//
// Ports:
//   Clk        rising-edge clock
//   Reset_n    asynchronous active-low reset; clears every valid bit
//   in_valid   A, B, cin and sub carry an operation this cycle
//   in_ready   the pipeline can take an operation this cycle
//   A, B       WIDTH-bit operands
//   cin        carry in (borrow in when sub=1)
//   sub        0: A+B+cin, 1: A-B-cin
//   out_valid  S, cout and ovf hold a completed result
//   out_ready  the consumer takes the result this cycle
//   S          WIDTH-bit sum or difference
//   cout       carry out of the MSB (1 means no borrow when sub=1)
//   ovf        signed two's-complement overflow
module pipelined_adder #(
   parameter int WIDTH = 16,
   parameter int CHUNK = 4
) (
   input  logic             Clk,
   input  logic             Reset_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             cin,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] S,
   output logic             cout,
   output logic             ovf
);

   localparam int STAGES = WIDTH / CHUNK;

   // Returns {carry out, carry into slice MSB, CHUNK-bit sum}.
   // The carry into the MSB is recovered from the sum bit, so no separate
   // (CHUNK-1)-bit adder is needed. This also works for CHUNK=1.
   function automatic logic [CHUNK+1:0] add_slice(input logic [CHUNK-1:0] a,
                                                  input logic [CHUNK-1:0] b,
                                                  input logic             c);
      logic [CHUNK:0] sum;
      logic           c_msb;
      sum   = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, c};
      c_msb = sum[CHUNK-1] ^ a[CHUNK-1] ^ b[CHUNK-1];
      return {sum[CHUNK], c_msb, sum[CHUNK-1:0]};
   endfunction

   logic             advance;
   logic [WIDTH-1:0] bop;
   logic             c0;

   logic [STAGES-1:0] vld_p;
   logic [WIDTH-1:0]  a_p [STAGES];
   logic [WIDTH-1:0]  b_p [STAGES];
   logic [WIDTH-1:0]  s_p [STAGES];
   logic [STAGES-1:0] c_p;
   logic              ovf_p;

   logic [WIDTH-1:0]  a_nxt [STAGES];
   logic [WIDTH-1:0]  b_nxt [STAGES];
   logic [WIDTH-1:0]  s_nxt [STAGES];
   logic [CHUNK+1:0]  r_nxt [STAGES];
   logic [STAGES-1:0] c_nxt;
   logic              ovf_nxt;

   // The whole pipe moves in lock-step. It stalls only while a finished
   // result is waiting for the consumer.
   assign advance  = !out_valid || out_ready;
   assign in_ready = advance;

   // Subtraction is A + ~B + 1 - cin. Inverting cin folds both the +1 and the
   // borrow into the stage-0 carry.
   assign bop = sub ? ~B : B;
   assign c0  = cin ^ sub;

   always_comb begin
      // Stage 0: slice 0 of the raw operands with the prepared carry.
      r_nxt[0]           = add_slice(A[CHUNK-1:0], bop[CHUNK-1:0], c0);
      a_nxt[0]           = A;
      b_nxt[0]           = bop;
      s_nxt[0]           = '0;
      s_nxt[0][CHUNK-1:0] = r_nxt[0][CHUNK-1:0];
      c_nxt[0]           = r_nxt[0][CHUNK+1];
      // Stages 1..STAGES-1: slice k of the operands delayed by k cycles.
      for (int k = 1; k < STAGES; k++) begin
         r_nxt[k] = add_slice(a_p[k-1][k*CHUNK +: CHUNK],
                              b_p[k-1][k*CHUNK +: CHUNK], c_p[k-1]);
         a_nxt[k] = a_p[k-1];
         b_nxt[k] = b_p[k-1];
         s_nxt[k] = s_p[k-1];
         s_nxt[k][k*CHUNK +: CHUNK] = r_nxt[k][CHUNK-1:0];
         c_nxt[k] = r_nxt[k][CHUNK+1];
      end
      // Overflow: carry into the word MSB XOR carry out of it. Both come
      // from the last slice.
      ovf_nxt = r_nxt[STAGES-1][CHUNK+1] ^ r_nxt[STAGES-1][CHUNK];
   end

   // Stage registers _p0.._p(STAGES-1). Data is not reset; the valid bits
   // decide what is real.
   always_ff @(posedge Clk) begin
      if (advance) begin
         for (int k = 0; k < STAGES; k++) begin
            a_p[k] <= a_nxt[k];
            b_p[k] <= b_nxt[k];
            s_p[k] <= s_nxt[k];
         end
         c_p   <= c_nxt;
         ovf_p <= ovf_nxt;
      end
   end

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         vld_p <= '0;
      end else if (advance) begin
         vld_p[0] <= in_valid;
         for (int k = 1; k < STAGES; k++) begin
            vld_p[k] <= vld_p[k-1];
         end
      end
   end

   // Output: the results are gated by valid. This keeps them at zero during
   // reset and for bubbles.
   assign out_valid = vld_p[STAGES-1];
   assign S         = out_valid ? s_p[STAGES-1] : '0;
   assign cout      = out_valid & c_p[STAGES-1];
   assign ovf       = out_valid & ovf_p;

endmodule

// File: tb/tb_pipelined_adder.sv
// Self-checking bench for pipelined_adder: a table of known vectors, a
// stall/stream sequence, a bubble pattern, reset mid-operation, a random
// stream checked against an arithmetic model, and two parameter variants.
module tb_pipelined_adder;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n;
   logic        in_valid, in_ready, cin, sub, out_valid, out_ready, cout, ovf;
   logic [15:0] a, b, s;

   logic        iv32, ir32, ov32, co32, of32;
   logic [31:0] a32, b32, s32;
   logic        iv8, ir8, ov8, co8, of8;
   logic [7:0]  a8, b8, s8;

   pipelined_adder #(.WIDTH(16), .CHUNK(4)) dut (
      .Clk(clk), .Reset_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .A(a), .B(b), .cin(cin), .sub(sub), .out_valid(out_valid),
      .out_ready(out_ready), .S(s), .cout(cout), .ovf(ovf));

   pipelined_adder #(.WIDTH(32), .CHUNK(8)) dut32 (
      .Clk(clk), .Reset_n(rst_n), .in_valid(iv32), .in_ready(ir32),
      .A(a32), .B(b32), .cin(1'b0), .sub(1'b0), .out_valid(ov32),
      .out_ready(1'b1), .S(s32), .cout(co32), .ovf(of32));

   pipelined_adder #(.WIDTH(8), .CHUNK(8)) dut8 (
      .Clk(clk), .Reset_n(rst_n), .in_valid(iv8), .in_ready(ir8),
      .A(a8), .B(b8), .cin(1'b0), .sub(1'b0), .out_valid(ov8),
      .out_ready(1'b1), .S(s8), .cout(co8), .ovf(of8));

   typedef struct {
      logic [15:0] a, b;
      logic        ci, sb;
      logic [15:0] s;
      logic        co, ov;
   } vec_t;

   typedef struct {
      logic [15:0] s;
      logic        co, ov;
      int          cyc;
   } exp_t;

   int   n_vec = 0;
   int   n_bad = 0;
   int   cyc   = 0;
   bit   lat_chk = 1'b0;
   exp_t exp_q[$];
   exp_t exp_cur;
   exp_t mon_e;
   exp_t mon_p;
   vec_t tbl[10];

   always @(posedge clk) cyc++;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      n_vec++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // Arithmetic reference: plain integer add/subtract, then range checks.
   task automatic model(input logic [15:0] ia, ib, input logic ic, isb,
                        output logic [15:0] os, output logic oco, oov);
      longint ua, ub, sa, sbv, c, r, sr;
      ua = ia; ub = ib; c = ic;
      sa = longint'($signed(ia)); sbv = longint'($signed(ib));
      if (!isb) begin
         r = ua + ub + c; oco = (r >= 65536); sr = sa + sbv + c;
      end else begin
         r = ua - ub - c; oco = (r >= 0);     sr = sa - sbv - c;
      end
      os  = r[15:0];
      oov = (sr > 32767) || (sr < -32768);
   endtask

   task automatic set_raw(input logic [15:0] ia, ib, input logic ic, isb,
                          input logic [15:0] es, input logic eco, eov);
      a = ia; b = ib; cin = ic; sub = isb;
      exp_cur.s = es; exp_cur.co = eco; exp_cur.ov = eov;
   endtask

   task automatic set_rand();
      logic [15:0] ra, rb, es;
      logic        rc, rs, eco, eov;
      ra = 16'($urandom); rb = 16'($urandom);
      rc = 1'($urandom); rs = 1'($urandom);
      model(ra, rb, rc, rs, es, eco, eov);
      set_raw(ra, rb, rc, rs, es, eco, eov);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drain(input int bound);
      in_valid  = 1'b0;
      out_ready = 1'b1;
      for (int i = 0; i < bound && exp_q.size() != 0; i++) tick();
      check("drain_empty", exp_q.size(), 0);
   endtask

   // Scoreboard: record accepted ops and compare each consumed result in order.
   always @(negedge clk) begin
      if (rst_n) begin
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               check("spurious_result", 1, 0);
            end else begin
               mon_e = exp_q.pop_front();
               check("sum", s, mon_e.s);
               check("cout", cout, mon_e.co);
               check("ovf", ovf, mon_e.ov);
               if (lat_chk) check("latency", cyc - mon_e.cyc, 4);
            end
         end
         if (in_valid && in_ready) begin
            mon_p = exp_cur;
            mon_p.cyc = cyc;
            exp_q.push_back(mon_p);
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, got timeout, want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bit          hist[20];
      int          k, st;
      logic [15:0] held;

      tbl[0] = '{16'h0078, 16'h03AB, 1'b0, 1'b0, 16'h0423, 1'b0, 1'b0};
      tbl[1] = '{16'h0378, 16'hFFFF, 1'b0, 1'b0, 16'h0377, 1'b1, 1'b0};
      tbl[2] = '{16'hC481, 16'hDD42, 1'b0, 1'b0, 16'hA1C3, 1'b1, 1'b0};
      tbl[3] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
      tbl[4] = '{16'h1100, 16'h0010, 1'b1, 1'b0, 16'h1111, 1'b0, 1'b0};
      tbl[5] = '{16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0};
      tbl[6] = '{16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0};
      tbl[7] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};
      tbl[8] = '{16'h0010, 16'h0001, 1'b1, 1'b1, 16'h000E, 1'b1, 1'b0};
      tbl[9] = '{16'hFFFF, 16'hFFFF, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0};

      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      a = '0; b = '0; cin = 1'b0; sub = 1'b0;
      iv32 = 1'b0; a32 = '0; b32 = '0; iv8 = 1'b0; a8 = '0; b8 = '0;
      exp_cur = '{16'h0, 1'b0, 1'b0, 0};

      // Reset state
      #12;
      check("rst_out_valid", out_valid, 0);
      check("rst_S", s, 0);
      check("rst_cout", cout, 0);
      check("rst_ovf", ovf, 0);
      rst_n = 1'b1;
      #1;
      check("post_rst_in_ready", in_ready, 1);
      tick();

      // Table vectors, back to back, fixed latency
      lat_chk = 1'b1;
      for (int i = 0; i < 10; i++) begin
         tick();
         set_raw(tbl[i].a, tbl[i].b, tbl[i].ci, tbl[i].sb, tbl[i].s, tbl[i].co, tbl[i].ov);
         in_valid = 1'b1;
      end
      tick();
      drain(30);
      lat_chk = 1'b0;

      // Streaming with a 3-cycle consumer stall once the first result shows
      k = 0;
      held = '0;
      for (int c = 0; c < 40 && !(k == 6 && exp_q.size() == 0); c++) begin
         tick();
         if (k < 6) begin set_rand(); in_valid = 1'b1; end
         else in_valid = 1'b0;
         out_ready = !(c >= 4 && c <= 6);
         @(negedge clk);
         if (c == 4) held = s;
         if (c >= 4 && c <= 6) begin
            check("stall_out_valid", out_valid, 1);
            check("stall_in_ready", in_ready, 0);
            if (c > 4) check("stall_hold_S", s, held);
         end
         if (in_valid && in_ready) k++;
      end
      check("stream_accepted", k, 6);
      drain(20);

      // Alternating bubbles: out_valid mirrors in_valid four cycles later
      lat_chk = 1'b1;
      for (int i = 0; i < 18; i++) begin
         tick();
         hist[i] = (i < 10) && (i % 2 == 0);
         if (hist[i]) set_rand();
         in_valid = hist[i];
         @(negedge clk);
         check("bubble_out_valid", out_valid, (i >= 4) ? hist[i-4] : 1'b0);
      end
      drain(20);
      lat_chk = 1'b0;

      // Asynchronous reset with three ops in flight
      out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin tick(); set_rand(); in_valid = 1'b1; end
      tick(); in_valid = 1'b0;
      repeat (3) tick();
      @(negedge clk);
      check("pre_reset_out_valid", out_valid, 1);
      #2 rst_n = 1'b0;
      #1;
      check("async_rst_out_valid", out_valid, 0);
      check("async_rst_S", s, 0);
      check("async_rst_cout", cout, 0);
      check("async_rst_ovf", ovf, 0);
      exp_q.delete();
      #10 rst_n = 1'b1;
      out_ready = 1'b1;
      for (int i = 0; i < 6; i++) begin
         tick();
         @(negedge clk);
         check("post_reset_idle", out_valid, 0);
      end
      lat_chk = 1'b1;
      tick();
      set_raw(16'h0078, 16'h03AB, 1'b0, 1'b0, 16'h0423, 1'b0, 1'b0);
      in_valid = 1'b1;
      tick();
      drain(20);
      lat_chk = 1'b0;

      // Random stream with random consumer back-pressure
      for (int i = 0; i < 400; i++) begin
         tick();
         in_valid  = ($urandom_range(0, 9) < 7);
         set_rand();
         out_ready = ($urandom_range(0, 3) != 0);
      end
      drain(50);

      // WIDTH=32, CHUNK=8
      tick();
      check("w32_in_ready", ir32, 1);
      a32 = 32'hFFFF_FFFF; b32 = 32'h0000_0001; iv32 = 1'b1;
      @(negedge clk); st = cyc;
      tick(); iv32 = 1'b0;
      for (int n = 0; n < 20 && !ov32; n++) @(negedge clk);
      check("w32_latency", cyc - st, 4);
      check("w32_out_valid", ov32, 1);
      check("w32_S", s32, 0);
      check("w32_cout", co32, 1);
      check("w32_ovf", of32, 0);

      // WIDTH=8, CHUNK=8 (single stage)
      tick();
      check("w8_in_ready", ir8, 1);
      a8 = 8'h7F; b8 = 8'h01; iv8 = 1'b1;
      @(negedge clk); st = cyc;
      tick(); iv8 = 1'b0;
      for (int n = 0; n < 20 && !ov8; n++) @(negedge clk);
      check("w8_latency", cyc - st, 1);
      check("w8_out_valid", ov8, 1);
      check("w8_S", s8, 8'h80);
      check("w8_cout", co8, 0);
      check("w8_ovf", of8, 1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
